keysw_io_responder: RTL and testbench

- Memory-mapped responder for the board inputs KEY[3:0] and SW[9:0].
- Sits on the processor's data-memory port beside the LED/HEX output registers (0xFFF8–0xFFFC).
- Answers CPU loads and stores in the 0xFFF0–0xFFF6 window (plus 0xFFFE when the IRQ option is built).
- Synchronizes and debounces the raw pins, latches key-press and switch-change events, and exposes write-1-to-clear status registers.

---
 rtl/keysw_io_responder_if.sv | 14 +
 rtl/keysw_io_responder.sv | 125 ++++++++++++
 tb/tb_keysw_io_responder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/keysw_io_responder_if.sv
// CPU data-port view of the KEY/SW responder: address, store strobe/data, read data and decode hit.
// The CPU drives the master side; the responder answers on the slave side.
interface keysw_io_responder_if #(
    parameter int DBITS = 16
);
    logic [DBITS-1:0] ADDR;
    logic             WE;
    logic [DBITS-1:0] DIN;
    logic [DBITS-1:0] DOUT;
    logic             HIT;

    modport master (output ADDR, output WE, output DIN, input DOUT, input HIT);
    modport slave  (input ADDR, input WE, input DIN, output DOUT, output HIT);
endinterface

// File: rtl/keysw_io_responder.sv
// Memory-mapped KEY/SW responder: 2-flop sync, per-bit debounce, W1C press/change events; optional IRQ via KEYSW_IRQ_EN.
// Loads are combinational (same cycle); pins reach KDATA/SDATA 2+DEB_CYCLES edges after a change; no backpressure.
module keysw_io_responder #(
    parameter int DBITS      = 16,
    parameter int DEB_CYCLES = 1000,
    parameter int DEB_BITS   = 10
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [3:0]           KEY,
    input  logic [9:0]           SW,
    keysw_io_responder_if.slave  bus
`ifdef KEYSW_IRQ_EN
    ,
    output logic                 IRQ
`endif
);
    localparam logic [DBITS-1:0] A_KDATA = DBITS'(16'hFFF0);
    localparam logic [DBITS-1:0] A_SDATA = DBITS'(16'hFFF2);
    localparam logic [DBITS-1:0] A_KEVT  = DBITS'(16'hFFF4);
    localparam logic [DBITS-1:0] A_SEVT  = DBITS'(16'hFFF6);
`ifdef KEYSW_IRQ_EN
    localparam logic [DBITS-1:0] A_IMASK = DBITS'(16'hFFFE);
`endif
    localparam logic [DEB_BITS-1:0] CNT_LAST = DEB_BITS'(DEB_CYCLES - 1);
    // Keys idle high (active-low buttons), switches start low.
    localparam logic [13:0] PIN_RST = {10'h000, 4'hF};

    logic [13:0]         sync1, sync2;
    logic [13:0]         deb, deb_nxt;
    logic [DEB_BITS-1:0] cnt [14];
    logic [3:0]          kpress;
    logic [9:0]          schg;
    logic [3:0]          kset, kclr;
    logic [9:0]          sset, sclr;
    logic [DBITS-1:0]    dout;
    logic                hit;
    logic                unused_din;

    assign unused_din = ^bus.DIN[DBITS-1:10];

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            sync1 <= PIN_RST;
            sync2 <= PIN_RST;
        end else begin
            sync1 <= {SW, KEY};
            sync2 <= sync1;
        end
    end

    // A bit commits only after DEB_CYCLES consecutive disagreeing cycles.
    always_comb begin
        deb_nxt = deb;
        for (int i = 0; i < 14; i++) begin
            if (sync2[i] != deb[i] && cnt[i] == CNT_LAST)
                deb_nxt[i] = sync2[i];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            deb <= PIN_RST;
            for (int i = 0; i < 14; i++)
                cnt[i] <= '0;
        end else begin
            deb <= deb_nxt;
            for (int i = 0; i < 14; i++) begin
                if (sync2[i] == deb[i] || cnt[i] == CNT_LAST)
                    cnt[i] <= '0;
                else
                    cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    assign kset = deb[3:0] & ~deb_nxt[3:0];
    assign sset = deb[13:4] ^ deb_nxt[13:4];
    assign kclr = (bus.WE && bus.ADDR == A_KEVT) ? bus.DIN[3:0] : 4'h0;
    assign sclr = (bus.WE && bus.ADDR == A_SEVT) ? bus.DIN[9:0] : 10'h000;

    // Set is ORed in after the clear so a same-cycle set survives the W1C.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            kpress <= 4'h0;
            schg   <= 10'h000;
        end else begin
            kpress <= (kpress & ~kclr) | kset;
            schg   <= (schg & ~sclr) | sset;
        end
    end

`ifdef KEYSW_IRQ_EN
    logic [13:0] imask;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            imask <= 14'h0000;
            IRQ   <= 1'b0;
        end else begin
            if (bus.WE && bus.ADDR == A_IMASK)
                imask <= bus.DIN[13:0];
            IRQ <= (|(kpress & imask[3:0])) | (|(schg & imask[13:4]));
        end
    end
`endif

    always_comb begin
        hit  = 1'b1;
        dout = DBITS'(16'hDEAD);
        case (bus.ADDR)
            A_KDATA: dout = DBITS'({12'h000, deb[3:0]});
            A_SDATA: dout = DBITS'({6'h00, deb[13:4]});
            A_KEVT:  dout = DBITS'({12'h000, kpress});
            A_SEVT:  dout = DBITS'({6'h00, schg});
`ifdef KEYSW_IRQ_EN
            A_IMASK: dout = DBITS'({2'b00, imask});
`endif
            default: hit = 1'b0;
        endcase
    end

    assign bus.DOUT = dout;
    assign bus.HIT  = hit;
endmodule

// File: tb/tb_keysw_io_responder.sv
// Directed bench for keysw_io_responder with DEB_CYCLES=4 (pin change visible 6 edges later).
// IRQ checks are compiled in when KEYSW_IRQ_EN is defined.
module tb_keysw_io_responder;
    logic       clk;
    logic       rst_n;
    logic [3:0] key;
    logic [9:0] sw;
    int         n_checks;
    int         n_fail;
`ifdef KEYSW_IRQ_EN
    logic       irq;
`endif

    keysw_io_responder_if #(.DBITS(16)) bus ();

    keysw_io_responder #(
        .DBITS(16),
        .DEB_CYCLES(4),
        .DEB_BITS(4)
    ) dut (
        .CLK(clk),
        .RESET_N(rst_n),
        .KEY(key),
        .SW(sw),
        .bus(bus)
`ifdef KEYSW_IRQ_EN
        ,
        .IRQ(irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [15:0] addr, input logic exp_hit, input logic [15:0] exp_dat,
                      input string tag);
        bus.ADDR = addr;
        #1;
        check({tag, "_hit"}, {31'b0, bus.HIT}, {31'b0, exp_hit});
        check({tag, "_dat"}, {16'b0, bus.DOUT}, {16'b0, exp_dat});
    endtask

    task automatic st(input logic [15:0] addr, input logic [15:0] dat);
        bus.ADDR = addr;
        bus.DIN  = dat;
        bus.WE   = 1'b1;
        tick();
        bus.WE   = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        key      = 4'hF;
        sw       = 10'h000;
        bus.ADDR = 16'h0000;
        bus.WE   = 1'b0;
        bus.DIN  = 16'h0000;
        repeat (3) tick();
        rst_n = 1'b1;

        rd(16'hFFF0, 1'b1, 16'h000F, "rst_kdata");
        rd(16'hFFF2, 1'b1, 16'h0000, "rst_sdata");
        rd(16'hFFF4, 1'b1, 16'h0000, "rst_kevt");
        rd(16'hFFF6, 1'b1, 16'h0000, "rst_sevt");
        rd(16'hFFF8, 1'b0, 16'hDEAD, "unmapped_fff8");
`ifdef KEYSW_IRQ_EN
        rd(16'hFFFE, 1'b1, 16'h0000, "rst_imask");
        check("rst_irq", {31'b0, irq}, 32'h0);
`else
        rd(16'hFFFE, 1'b0, 16'hDEAD, "noirq_fffe");
`endif

        // Clean press on KEY[0]: committed on the 6th edge after the change.
        key = 4'hE;
        repeat (5) tick();
        rd(16'hFFF0, 1'b1, 16'h000F, "press_edge5_kdata");
        tick();
        rd(16'hFFF0, 1'b1, 16'h000E, "press_edge6_kdata");
        rd(16'hFFF4, 1'b1, 16'h0001, "press_kevt");
        st(16'hFFF4, 16'h0001);
        rd(16'hFFF4, 1'b1, 16'h0000, "kevt_w1c");
        st(16'hFFF0, 16'h0000);
        rd(16'hFFF0, 1'b1, 16'h000E, "ro_store_ignored");
        key = 4'hF;
        repeat (6) tick();
        rd(16'hFFF0, 1'b1, 16'h000F, "release_kdata");
        rd(16'hFFF4, 1'b1, 16'h0000, "release_no_evt");

        // 3-cycle glitch on KEY[1] must be rejected.
        key = 4'hD;
        repeat (3) tick();
        key = 4'hF;
        repeat (8) tick();
        rd(16'hFFF0, 1'b1, 16'h000F, "glitch_kdata");
        rd(16'hFFF4, 1'b1, 16'h0000, "glitch_kevt");

        // Switch change and selective W1C.
        sw = 10'h201;
        repeat (5) tick();
        rd(16'hFFF2, 1'b1, 16'h0000, "sw_edge5_sdata");
        tick();
        rd(16'hFFF2, 1'b1, 16'h0201, "sw_sdata");
        rd(16'hFFF6, 1'b1, 16'h0201, "sw_sevt");
        st(16'hFFF6, 16'h0001);
        rd(16'hFFF6, 1'b1, 16'h0200, "sevt_clr_bit0");
        st(16'hFFF6, 16'h0200);
        rd(16'hFFF6, 1'b1, 16'h0000, "sevt_clr_bit9");

        // W1C on the very edge KEY[2] commits: set wins.
        key = 4'hB;
        repeat (5) tick();
        st(16'hFFF4, 16'h0004);
        rd(16'hFFF4, 1'b1, 16'h0004, "set_wins_kevt");
        rd(16'hFFF0, 1'b1, 16'h000B, "set_wins_kdata");
        st(16'hFFF4, 16'h0004);
        rd(16'hFFF4, 1'b1, 16'h0000, "set_wins_clear");
        key = 4'hF;
        repeat (6) tick();
        rd(16'hFFF0, 1'b1, 16'h000F, "kdata_idle");

        // Reset in the middle of a KEY[0] debounce; SW still high.
        key = 4'hE;
        repeat (2) tick();
        rst_n = 1'b0;
`ifdef KEYSW_IRQ_EN
        bus.ADDR = 16'hFFFE;
        bus.DIN  = 16'h0001;
        bus.WE   = 1'b1;
`endif
        tick();
        bus.WE = 1'b0;
        rd(16'hFFF0, 1'b1, 16'h000F, "inrst_kdata");
        rd(16'hFFF2, 1'b1, 16'h0000, "inrst_sdata");
        rd(16'hFFF4, 1'b1, 16'h0000, "inrst_kevt");
`ifdef KEYSW_IRQ_EN
        rd(16'hFFFE, 1'b1, 16'h0000, "inrst_imask_store_ignored");
`endif
        rst_n = 1'b1;
        repeat (5) tick();
        rd(16'hFFF0, 1'b1, 16'h000F, "postrst_edge5_kdata");
        tick();
        rd(16'hFFF0, 1'b1, 16'h000E, "postrst_edge6_kdata");
        rd(16'hFFF4, 1'b1, 16'h0001, "postrst_kevt");
        rd(16'hFFF2, 1'b1, 16'h0201, "postrst_sdata");
        rd(16'hFFF6, 1'b1, 16'h0201, "postrst_sevt");

`ifdef KEYSW_IRQ_EN
        st(16'hFFF4, 16'h000F);
        st(16'hFFF6, 16'h03FF);
        key = 4'hF;
        repeat (6) tick();
        st(16'hFFFE, 16'h0001);
        rd(16'hFFFE, 1'b1, 16'h0001, "imask_rw");
        tick();
        check("irq_idle", {31'b0, irq}, 32'h0);
        key = 4'hE;
        repeat (6) tick();
        rd(16'hFFF4, 1'b1, 16'h0001, "irq_kevt");
        check("irq_lag", {31'b0, irq}, 32'h0);
        tick();
        check("irq_set", {31'b0, irq}, 32'h1);
        st(16'hFFF4, 16'h0001);
        check("irq_hold_at_clear", {31'b0, irq}, 32'h1);
        tick();
        check("irq_fall", {31'b0, irq}, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
